// File: rtl/uart_rx_mmio_pkg.sv
// Shared types and register offsets for the uart_rx_mmio serial receiver.
package uart_rx_mmio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  // Byte offsets of the register words on the data bus.
  localparam logic [3:0] UART_RX_DATA   = 4'h0;
  localparam logic [3:0] UART_RX_STATUS = 4'h4;
  localparam logic [3:0] UART_RX_CTRL   = 4'h8;
  localparam logic [3:0] UART_RX_DIV    = 4'hC;

  // Ticks per serial bit and the tick index of the mid-bit sample point.
  localparam logic [3:0] UART_RX_LAST_TICK = 4'd15;
  localparam logic [3:0] UART_RX_HALF_TICK = 4'd7;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received characters. Pointers carry one extra MSB
// so that full and empty are distinguishable when the index bits match.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [7:0]       wdata_i,
  input  logic             pop_i,
  output logic [7:0]       rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           wr_en;
  logic           rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem[rd_ptr_q[PTR_W-1:0]];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; on a full push+pop the written slot is the one being popped.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 serial receiver: 2-flop line synchronizer, 16x oversampled
// frame FSM, receive FIFO, DATA/STATUS/CTRL/DIV registers with one-cycle read
// latency, and a registered level interrupt.
// Build option UART_RX_PARITY_EN adds a parity stage (CTRL.PEN, CTRL.ODD,
// STATUS.PE); without it those bits read 0.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd1,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic              rx_i,
  output logic              irq_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic rx_meta_q, rx_s_q;

  uart_rx_state_e state_q, state_d;
  logic [15:0] div_q, div_act_q;
  logic [15:0] tick_cnt_q;
  logic        tick;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        fe_wait_q, fe_wait_d;
  logic        par_err_q, par_err_d;
  logic        push, set_fe, set_pe;

  logic [3:0]  ctrl_q;
  logic        oe_q, fe_q, pe_q;
  logic        rx_en, pen, odd;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             set_oe;

  logic [ADDR_W-1:0] addr_w;
  logic        sel_data, sel_status, sel_ctrl, sel_div;
  logic        rd_acc, wr_acc;
  logic        clr_oe, clr_fe, clr_pe;
  logic [31:0] rdata;
  logic [31:0] data_q;
  logic        irq_q;
  logic        unused_bits;

`ifdef UART_RX_PARITY_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
  assign pen = ctrl_q[2];
  assign odd = ctrl_q[3];
`else
  localparam logic [3:0] CTRL_MASK = 4'h3;
  assign pen = 1'b0;
  assign odd = 1'b0;
`endif

  assign rx_en       = ctrl_q[0];
  assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

  // Two-flop synchronizer; the line idles high so reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (tick_cnt_q == div_act_q);

  // Oversample tick divider; a new DIV value is adopted only at a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      div_act_q  <= DEFAULT_DIV;
    end else if (!rx_en || state_q == IDLE || tick) begin
      tick_cnt_q <= '0;
      div_act_q  <= div_q;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  // Frame FSM next state: start qualification, data bits, parity, stop.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    fe_wait_d  = fe_wait_q;
    par_err_d  = par_err_q;
    push       = 1'b0;
    set_fe     = 1'b0;
    set_pe     = 1'b0;
    if (!rx_en) begin
      state_d    = IDLE;
      samp_cnt_d = '0;
      bit_cnt_d  = '0;
      fe_wait_d  = 1'b0;
      par_err_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          fe_wait_d  = 1'b0;
          par_err_d  = 1'b0;
          if (!rx_s_q) state_d = START;
        end
        START: begin
          if (tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
            if (samp_cnt_q == UART_RX_HALF_TICK) begin
              samp_cnt_d = '0;
              state_d    = rx_s_q ? IDLE : DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
            if (samp_cnt_q == UART_RX_LAST_TICK) begin
              shift_d   = {rx_s_q, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_d = pen ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
            if (samp_cnt_q == UART_RX_LAST_TICK) begin
              if (rx_s_q != ((^shift_q) ^ odd)) begin
                set_pe    = 1'b1;
                par_err_d = 1'b1;
              end
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (fe_wait_q) begin
            // Hold off until the line is released so a long break is not
            // mistaken for a new start bit.
            if (rx_s_q) state_d = IDLE;
          end else if (tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
            if (samp_cnt_q == UART_RX_LAST_TICK) begin
              if (rx_s_q) begin
                push    = !par_err_q;
                state_d = IDLE;
              end else begin
                set_fe    = 1'b1;
                fe_wait_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame FSM control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      fe_wait_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      fe_wait_q  <= fe_wait_d;
      par_err_q  <= par_err_d;
    end
  end

  // Receive shift register (data only, no reset needed).
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign addr_w     = {addr_i[ADDR_W-1:2], 2'b00};
  assign sel_data   = (addr_w == ADDR_W'(UART_RX_DATA));
  assign sel_status = (addr_w == ADDR_W'(UART_RX_STATUS));
  assign sel_ctrl   = (addr_w == ADDR_W'(UART_RX_CTRL));
  assign sel_div    = (addr_w == ADDR_W'(UART_RX_DIV));
  assign rd_acc     = en_i && (we_i == 4'b0000);
  assign wr_acc     = en_i && (we_i != 4'b0000);

  assign fifo_pop = rd_acc && sel_data && !fifo_empty;
  assign set_oe   = push && fifo_full && !fifo_pop;
  assign clr_oe   = wr_acc && sel_status && we_i[0] && data_i[2];
  assign clr_fe   = wr_acc && sel_status && we_i[0] && data_i[3];
  assign clr_pe   = wr_acc && sel_status && we_i[0] && data_i[4];

  // Read mux for the addressed register.
  always_comb begin
    rdata = '0;
    if (sel_data) begin
      if (!fifo_empty) rdata = {23'd0, 1'b1, fifo_head};
    end else if (sel_status) begin
      rdata = {16'd0, 8'(fifo_count), 3'd0, pe_q, fe_q, oe_q, fifo_full, !fifo_empty};
    end else if (sel_ctrl) begin
      rdata = {28'd0, ctrl_q};
    end else if (sel_div) begin
      rdata = {16'd0, div_q};
    end
  end

  // Programmable registers and sticky error flags; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      div_q  <= DEFAULT_DIV;
      oe_q   <= 1'b0;
      fe_q   <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      if (wr_acc && sel_ctrl && we_i[0]) ctrl_q <= data_i[3:0] & CTRL_MASK;
      if (wr_acc && sel_div && we_i[0]) div_q[7:0]  <= data_i[7:0];
      if (wr_acc && sel_div && we_i[1]) div_q[15:8] <= data_i[15:8];
      oe_q <= (oe_q && !clr_oe) || set_oe;
      fe_q <= (fe_q && !clr_fe) || set_fe;
      pe_q <= (pe_q && !clr_pe) || set_pe;
    end
  end

  // Registered read data and interrupt level.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= rd_acc ? rdata : 32'd0;
      irq_q  <= ctrl_q[1] && (!fifo_empty || oe_q || fe_q || pe_q);
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule
